prescaled_counter: RTL and testbench
====================================

# prescaled_counter

Parametrised free-running counter for board-level LED/heartbeat displays. It replaces the divided-clock counter style with a single-clock design: an internal prescaler generates a clock-enable tick, and the counter advances on each tick. Adds count width, tick period, up/down direction, parallel load and wrap/saturate mode. Sits directly behind the top-level clock buffer and drives LED pins or downstream status logic.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits; legal range is 1..32.
- `TICK_DIV`, 2097152: clock cycles per counter step; legal values are ≥ 1, and 1 means a step every cycle.
- `SATURATE`, 0: 0 wraps at the bounds; 1 holds at the bounds.

Ports:
- `CLK` in 1: single clock. All state changes on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `EN_run` in 1: level. High lets the prescaler run and the counter step. Low freezes both.
- `up` in 1: direction. 1 counts up, 0 counts down. Sampled at each step edge.
- `EN_load` in 1: one-cycle load request. Honoured only while `RDY_load` = 1.
- `load_value` in WIDTH: value loaded when `EN_load` is honoured.
- `RDY_load` out 1: the load method is ready.
- `count_value` out WIDTH: current count, registered.
- `RDY_count_value` out 1: `count_value` is valid.
- `tick` out 1: registered one-cycle pulse that marks a step.
- `wrap` out 1: registered one-cycle pulse that marks a bound event.

## Operation
- **State.** The block holds these registers: prescaler `p` (width clog2(TICK_DIV), minimum 1), `count`, `ready`, `tick`, `wrap`.
- **Reset (RST_N low, asynchronous).**
  - `p` = 0, `count` = 0, `tick` = 0, `wrap` = 0, `ready` = 0.
  - Outputs follow immediately: `count_value` = 0, `RDY_load` = 0, `RDY_count_value` = 0.
- **Ready.** `ready` sets on the first rising edge after RST_N deasserts and stays 1. `RDY_load` = `RDY_count_value` = `ready`.
- **Edge priority.** Evaluated in this order on every edge while `ready` = 1:
  1. **Load** (`EN_load` = 1):
     - `count` ← `load_value`, `p` ← 0, `tick` ← 0, `wrap` ← 0.
     - A step due on the same edge is discarded.
     - Loading works even while `EN_run` = 0.
  2. **Step** (`EN_run` = 1 and `p` = TICK_DIV−1):
     - `p` ← 0, `tick` ← 1, and `count` ← next.
     - `wrap` ← 1 if `count` was at the bound in the direction of travel (MAX = 2^WIDTH−1 when counting up, 0 when counting down); otherwise `wrap` ← 0.
  3. **Run** (`EN_run` = 1 otherwise): `p` ← `p`+1, `tick` ← 0, `wrap` ← 0.
  4. **Frozen** (`EN_run` = 0): `p` and `count` hold, `tick` ← 0, `wrap` ← 0.
- **Next-count rules.** All arithmetic is modulo 2^WIDTH.
  - Up, not at MAX: `count`+1.
  - Down, not at 0: `count`−1.
  - Up at MAX: 0 when SATURATE = 0; stays MAX when SATURATE = 1.
  - Down at 0: MAX when SATURATE = 0; stays 0 when SATURATE = 1.
- **Wrap in saturate mode.** `wrap` pulses on every step taken at the bound, including repeated steps while held there.
- **Edges before ready.** While `ready` = 0, `EN_load` and `EN_run` are ignored and all state holds its reset value.

## Timing
- **Step period.** A step occurs every TICK_DIV cycles of continuous `EN_run`.
  - The first step after reset or load comes TICK_DIV edges after `EN_run` is first sampled high (with `ready` = 1).
- **Tick alignment.** `tick` and `wrap` are high for exactly one cycle: the same cycle in which `count_value` first shows the new value.
  - With TICK_DIV = 1 and `EN_run` held high, `tick` stays high continuously.
- **Load latency.** `count_value` = `load_value` in the cycle after the `EN_load` edge. The next step follows TICK_DIV cycles later.
- **Freezing.** Deasserting `EN_run` freezes `p` mid-period. Reasserting it resumes from the stored `p`; no cycles are lost or added.
- **Direction change.** `up` takes effect at the next step edge only; it has no effect on `p`.
- **Reset mid-period.** Asserting RST_N clears all state asynchronously. Any in-flight `tick` or `wrap` pulse drops immediately.

## Test plan
All scenarios use WIDTH = 4 and TICK_DIV = 3 unless noted.
- **Reset.** Hold RST_N = 0 with `EN_run` = 1, then release.
  - Required: `count_value` = 0 and RDY_* = 0 while in reset; RDY_* = 1 one edge after release.
  - Required: first `tick` 3 cycles after `ready`, with `count_value` = 1 in that cycle.
- **Up-wrap.** Load 14, `up` = 1, SATURATE = 0.
  - Required: counts 14 → 15 → 0 → 1 at 3-cycle spacing.
  - Required: `wrap` pulses only with the 15 → 0 step, coincident with `tick`.
- **Down-saturate.** SATURATE = 1, load 1, `up` = 0.
  - Required: 1 → 0 with no wrap, then 0 → 0 with `wrap` = 1 on each subsequent tick.
  - Then switch `up` = 1: next tick gives 1 with `wrap` = 0.
- **Load vs step collision.** Assert `EN_load` with `load_value` = 9 on the exact edge where `p` = 2.
  - Required: `count_value` = 9 and `tick` = 0 on the next cycle; following tick 3 cycles later gives 10.
- **Freeze.** Drop `EN_run` for 5 cycles at `p` = 1, then raise it.
  - Required: no ticks while frozen; next tick exactly 2 run-cycles after resume.
- **Async reset mid-run.** Pulse RST_N low for half a cycle while `count_value` = 7 and `tick` = 1.
  - Required: `count_value` = 0 and `tick` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prescaled_counter.sv
// Free-running counter that steps on an internal prescaler tick instead of a divided clock.
// Supports up/down counting, parallel load, and either wrap or saturate behaviour at the bounds.
module prescaled_counter #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 2097152,
   parameter int SATURATE = 0
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN_run,
   input  logic             up,
   input  logic             EN_load,
   input  logic [WIDTH-1:0] load_value,
   output logic             RDY_load,
   output logic [WIDTH-1:0] count_value,
   output logic             RDY_count_value,
   output logic             tick,
   output logic             wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] MAX = '1;
   localparam bit SAT = (SATURATE != 0);

   logic [PW-1:0]    p;
   logic [PW-1:0]    p_next;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] stepped;
   logic             at_bound;
   logic             ready;
   logic             tick_next;
   logic             wrap_next;

   // Candidate count for a step; in saturate mode the bound value simply holds.
   always_comb begin
      at_bound = up ? (count == MAX) : (count == '0);
      if (at_bound && SAT)
         stepped = count;
      else if (up)
         stepped = count + WIDTH'(1);
      else
         stepped = count - WIDTH'(1);
   end

   // Load beats a step due on the same edge; a frozen prescaler keeps its phase.
   always_comb begin
      p_next     = p;
      count_next = count;
      tick_next  = 1'b0;
      wrap_next  = 1'b0;
      if (EN_load) begin
         count_next = load_value;
         p_next     = '0;
      end else if (EN_run) begin
         if (p == P_LAST) begin
            p_next     = '0;
            count_next = stepped;
            tick_next  = 1'b1;
            wrap_next  = at_bound;
         end else begin
            p_next = p + PW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p     <= '0;
         count <= '0;
         ready <= 1'b0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
      end else if (!ready) begin
         ready <= 1'b1;
      end else begin
         p     <= p_next;
         count <= count_next;
         tick  <= tick_next;
         wrap  <= wrap_next;
      end
   end

   assign count_value     = count;
   assign RDY_load        = ready;
   assign RDY_count_value = ready;

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: a wrapping and a saturating instance share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_prescaled_counter;

   localparam int WIDTH    = 4;
   localparam int TICK_DIV = 3;
   localparam int LIMIT    = (1 << WIDTH) - 1;

   logic             clk;
   logic             rst_n;
   logic             enRun;
   logic             up;
   logic             enLoad;
   logic [WIDTH-1:0] loadValue;

   logic             rdyLoadW, rdyCountW, tickW, wrapW;
   logic [WIDTH-1:0] countW;
   logic             rdyLoadS, rdyCountS, tickS, wrapS;
   logic [WIDTH-1:0] countS;

   int checkCount  = 0;
   int errorCount  = 0;
   bit checkEnable = 0;

   int mPhase    = 0;
   int mCount[2] = '{0, 0};
   bit mTick[2]  = '{0, 0};
   bit mWrap[2]  = '{0, 0};
   bit mReady    = 0;

   prescaled_counter #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .SATURATE(0)) dutWrap (
      .CLK(clk), .RST_N(rst_n), .EN_run(enRun), .up(up), .EN_load(enLoad),
      .load_value(loadValue), .RDY_load(rdyLoadW), .count_value(countW),
      .RDY_count_value(rdyCountW), .tick(tickW), .wrap(wrapW)
   );

   prescaled_counter #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .SATURATE(1)) dutSat (
      .CLK(clk), .RST_N(rst_n), .EN_run(enRun), .up(up), .EN_load(enLoad),
      .load_value(loadValue), .RDY_load(rdyLoadS), .count_value(countS),
      .RDY_count_value(rdyCountS), .tick(tickS), .wrap(wrapS)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single point of comparison: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: counts elapsed run cycles and steps once TICK_DIV of them have passed.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mReady = 0;
            mPhase = 0;
            for (int i = 0; i < 2; i++) begin
               mCount[i] = 0;
               mTick[i]  = 0;
               mWrap[i]  = 0;
            end
         end else if (!mReady) begin
            mReady = 1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               mTick[i] = 0;
               mWrap[i] = 0;
            end
            if (enLoad) begin
               mPhase = 0;
               for (int i = 0; i < 2; i++) mCount[i] = int'(loadValue);
            end else if (enRun) begin
               mPhase = mPhase + 1;
               if (mPhase == TICK_DIV) begin
                  mPhase = 0;
                  for (int i = 0; i < 2; i++) begin
                     mTick[i] = 1;
                     mWrap[i] = up ? (mCount[i] == LIMIT) : (mCount[i] == 0);
                     if (mWrap[i] && i == 1)
                        mCount[i] = mCount[i];
                     else if (up)
                        mCount[i] = (mCount[i] + 1) % (LIMIT + 1);
                     else
                        mCount[i] = (mCount[i] + LIMIT) % (LIMIT + 1);
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checkEnable) begin
         checkOutput("count_w", countW, mCount[0]);
         checkOutput("tick_w", tickW, mTick[0]);
         checkOutput("wrap_w", wrapW, mWrap[0]);
         checkOutput("rdy_load_w", rdyLoadW, mReady);
         checkOutput("rdy_count_w", rdyCountW, mReady);
         checkOutput("count_s", countS, mCount[1]);
         checkOutput("tick_s", tickS, mTick[1]);
         checkOutput("wrap_s", wrapS, mWrap[1]);
         checkOutput("rdy_load_s", rdyLoadS, mReady);
         checkOutput("rdy_count_s", rdyCountS, mReady);
      end
   end

   task automatic applyStimulus(input logic run, input logic dir, input logic load, input logic [WIDTH-1:0] value);
      @(posedge clk);
      #1;
      enRun     = run;
      up        = dir;
      enLoad    = load;
      loadValue = value;
   endtask

   // One-cycle load request; returns 1 time unit after the edge that performs the load.
   task automatic loadCounter(input logic [WIDTH-1:0] value);
      @(posedge clk);
      #1;
      enLoad    = 1'b1;
      loadValue = value;
      @(posedge clk);
      #1;
      enLoad = 1'b0;
   endtask

   // Counts edges until tick is seen just after an edge; an expired budget is a failure.
   task automatic waitTick(input int budget, output int cycles);
      bit found;
      found  = 0;
      cycles = 0;
      for (int n = 1; n <= budget && !found; n++) begin
         @(posedge clk);
         #1;
         if (tickW === 1'b1) begin
            found  = 1;
            cycles = n;
         end
      end
      if (!found) checkOutput("tick_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int frozenTicks;
      rst_n     = 1'b0;
      enRun     = 1'b1;
      up        = 1'b1;
      enLoad    = 1'b0;
      loadValue = '0;

      repeat (3) @(posedge clk);
      #1;
      checkEnable = 1;
      checkOutput("reset_count", countW, 32'd0);
      checkOutput("reset_rdy", rdyLoadW, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_release", rdyCountW, 32'd1);
      waitTick(10, n);
      checkOutput("first_tick_delay", n, 32'd3);
      checkOutput("first_tick_count", countW, 32'd1);

      // Up-wrap: 14 -> 15 -> 0 -> 1 on the wrapping instance, holds at 15 on the saturating one.
      up = 1'b1;
      loadCounter(4'd14);
      waitTick(10, n);
      checkOutput("upwrap_gap1", n, 32'd3);
      checkOutput("upwrap_cnt1", countW, 32'd15);
      checkOutput("upwrap_wrap1", wrapW, 32'd0);
      waitTick(10, n);
      checkOutput("upwrap_gap2", n, 32'd3);
      checkOutput("upwrap_cnt2", countW, 32'd0);
      checkOutput("upwrap_wrap2", wrapW, 32'd1);
      checkOutput("upsat_cnt2", countS, 32'd15);
      checkOutput("upsat_wrap2", wrapS, 32'd1);
      waitTick(10, n);
      checkOutput("upwrap_cnt3", countW, 32'd1);
      checkOutput("upwrap_wrap3", wrapW, 32'd0);
      checkOutput("upsat_wrap3", wrapS, 32'd1);

      // Down-saturate on the saturating instance, then reverse direction.
      up = 1'b0;
      loadCounter(4'd1);
      waitTick(10, n);
      checkOutput("downsat_cnt1", countS, 32'd0);
      checkOutput("downsat_wrap1", wrapS, 32'd0);
      waitTick(10, n);
      checkOutput("downsat_cnt2", countS, 32'd0);
      checkOutput("downsat_wrap2", wrapS, 32'd1);
      checkOutput("downwrap_cnt2", countW, 32'd15);
      waitTick(10, n);
      checkOutput("downsat_wrap3", wrapS, 32'd1);
      up = 1'b1;
      waitTick(10, n);
      checkOutput("downsat_rev_cnt", countS, 32'd1);
      checkOutput("downsat_rev_wrap", wrapS, 32'd0);

      // Load on the very edge where a step is due: the step is discarded.
      loadCounter(4'd4);
      @(posedge clk);
      @(posedge clk);
      #1;
      enLoad    = 1'b1;
      loadValue = 4'd9;
      @(posedge clk);
      #1;
      enLoad = 1'b0;
      checkOutput("collide_cnt", countW, 32'd9);
      checkOutput("collide_tick", tickW, 32'd0);
      waitTick(10, n);
      checkOutput("collide_gap", n, 32'd3);
      checkOutput("collide_next", countW, 32'd10);

      // Freeze with one run cycle already accumulated.
      loadCounter(4'd2);
      @(posedge clk);
      #1;
      enRun       = 1'b0;
      frozenTicks = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (tickW) frozenTicks++;
      end
      checkOutput("freeze_ticks", frozenTicks, 32'd0);
      checkOutput("freeze_hold", countW, 32'd2);
      enRun = 1'b1;
      waitTick(10, n);
      checkOutput("freeze_resume_gap", n, 32'd2);
      checkOutput("freeze_resume_cnt", countW, 32'd3);

      // Asynchronous reset in the middle of a tick cycle.
      loadCounter(4'd6);
      waitTick(10, n);
      checkOutput("preasync_cnt", countW, 32'd7);
      checkOutput("preasync_tick", tickW, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_cnt", countW, 32'd0);
      checkOutput("async_tick", tickW, 32'd0);
      checkOutput("async_wrap_s", wrapS, 32'd0);
      checkOutput("async_rdy", rdyLoadS, 32'd0);
      #1;
      rst_n = 1'b1;

      // Randomized traffic, checked every cycle against the model.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 19) == 0, 4'($urandom_range(0, LIMIT)));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
      @(negedge clk);
      checkEnable = 0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
